// File: rtl/rtc_control_if.sv
// Multiplexed address/data bus between the controller and the RTC chip.
// All strobes are active-low. A transaction is four equal phases:
//   1: cs=0 a_d=0 wr=0, dato_oe=1, dato_o = register address
//   2: strobes high, bus released
//   3: cs=0 a_d=1, then either wr=0 with dato_oe=1 and dato_o = data (write)
//      or rd=0 with the bus released and dato_i sampled on the last cycle (read)
//   4: strobes high, bus released
// dato_oe=0 means the controller leaves the bus in Hi-Z.
interface rtc_control_if;
  logic [7:0] dato_o;
  logic [7:0] dato_i;
  logic       dato_oe;
  logic       a_d;
  logic       cs;
  logic       rd;
  logic       wr;
  logic [2:0] dbg_state;

  modport master (output dato_o, dato_oe, a_d, cs, rd, wr, dbg_state, input dato_i);
  modport slave  (input dato_o, dato_oe, a_d, cs, rd, wr, dbg_state, output dato_i);
endinterface

// File: rtl/rtc_control.sv
// RTC chip controller: polls clock/date/timer registers, supports user edits
// with write-back, alarm on armed timer expiry, and 12/24 h hour display.
module rtc_control #(
  parameter int PH = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw0,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       enUP,
  input  logic       enDOWN,
  input  logic       enRIGHT,
  input  logic       enLEFT,
  input  logic       desactivar_alarma,
  input  logic       formato_hora,
  rtc_control_if.master bus,
  output logic [7:0] out_seg_hora,
  output logic [7:0] out_min_hora,
  output logic [7:0] out_hora_hora,
  output logic [7:0] out_dia_fecha,
  output logic [7:0] out_mes_fecha,
  output logic [7:0] out_jahr_fecha,
  output logic [7:0] out_dia_semana,
  output logic [7:0] out_seg_timer,
  output logic [7:0] out_min_timer,
  output logic [7:0] out_hora_timer,
  output logic       estado_alarma,
  output logic [1:0] cursor_location,
  output logic       AM_PM
);
  localparam int CW = (PH > 1) ? $clog2(PH) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_P1, ST_P2, ST_P3, ST_P4} st_t;

  // Register index 0..9 follows the polling order; groups: 1=time 2=date 3=timer.
  function automatic logic [1:0] grp_of(input logic [3:0] i);
    if (i < 4'd3) return 2'd1;
    if (i < 4'd6) return 2'd2;
    if (i == 4'd6) return 2'd0;
    return 2'd3;
  endfunction

  function automatic logic [3:0] base_of(input logic [1:0] g);
    case (g)
      2'd2:    return 4'd3;
      2'd3:    return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] addr_of(input logic [3:0] i);
    if (i < 4'd7) return 8'h21 + {4'h0, i};
    return 8'h41 + {4'h0, i - 4'd7};
  endfunction

  function automatic logic [7:0] hi_of(input logic [3:0] i);
    case (i)
      4'd2, 4'd9: return 8'h23;
      4'd3:       return 8'h31;
      4'd4:       return 8'h12;
      4'd5:       return 8'h99;
      default:    return 8'h59;
    endcase
  endfunction

  function automatic logic [7:0] lo_of(input logic [3:0] i);
    return (i == 4'd3 || i == 4'd4) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (v >= hi) return lo;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (v <= lo || v > hi) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'h9};
    return v - 8'd1;
  endfunction

  st_t           st_q;
  logic [CW-1:0] cnt_q;
  logic          cs_q, rd_q, wr_q, a_d_q, oe_q;
  logic [7:0]    dato_q;
  logic [7:0]    val_q [10];
  logic [3:0]    poll_q, cur_idx_q;
  logic          is_wr_q;
  logic [7:0]    wdata_q, rdata_q;
  logic          wr_pend_q;
  logic [1:0]    wr_grp_q, wr_idx_q;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    cursor_q;
  logic          armed_q, estado_q;

  logic          ph_last, start, store, alarm_set, rd_blocked;
  logic [1:0]    cur_grp;
  logic [3:0]    nxt_idx, fi;

  assign ph_last = (cnt_q == CW'(PH - 1));
  assign start   = (st_q == ST_IDLE) || (st_q == ST_P4 && ph_last);

  // Mode selection, next transaction choice, read-store gating and alarm detection
  always_comb begin
    mode_d     = sw0 ? 2'd1 : sw1 ? 2'd2 : sw2 ? 2'd3 : 2'd0;
    nxt_idx    = wr_pend_q ? base_of(wr_grp_q) + {2'b00, wr_idx_q} : poll_q;
    fi         = base_of(mode_q) + {2'b00, cursor_q};
    cur_grp    = grp_of(cur_idx_q);
    // A group being edited, or still waiting for its write-back, must not be overwritten by polls.
    rd_blocked = (cur_grp != 2'd0) &&
                 ((cur_grp == mode_q) || (wr_pend_q && cur_grp == wr_grp_q));
    store      = start && (st_q == ST_P4) && !is_wr_q && !rd_blocked;
    alarm_set  = store && (cur_idx_q == 4'd9) && armed_q &&
                 (val_q[7] == 8'h00) && (val_q[8] == 8'h00) && (rdata_q == 8'h00);
  end

  // Bus FSM, register file, edit handling and alarm state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      a_d_q     <= 1'b0;
      oe_q      <= 1'b0;
      dato_q    <= 8'h00;
      for (int i = 0; i < 10; i++) val_q[i] <= 8'h00;
      poll_q    <= 4'd0;
      cur_idx_q <= 4'd0;
      is_wr_q   <= 1'b0;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      wr_pend_q <= 1'b0;
      wr_grp_q  <= 2'd0;
      wr_idx_q  <= 2'd0;
      mode_q    <= 2'd0;
      cursor_q  <= 2'd0;
      armed_q   <= 1'b0;
      estado_q  <= 1'b0;
    end else begin
      if (start) begin
        if (store) val_q[cur_idx_q] <= rdata_q;
        if (alarm_set) armed_q <= 1'b0;
        st_q      <= ST_P1;
        cnt_q     <= '0;
        cs_q      <= 1'b0;
        a_d_q     <= 1'b0;
        wr_q      <= 1'b0;
        rd_q      <= 1'b1;
        oe_q      <= 1'b1;
        dato_q    <= addr_of(nxt_idx);
        cur_idx_q <= nxt_idx;
        is_wr_q   <= wr_pend_q;
        wdata_q   <= val_q[nxt_idx];
        if (wr_pend_q) begin
          if (wr_idx_q == 2'd2) wr_pend_q <= 1'b0;
          wr_idx_q <= wr_idx_q + 2'd1;
        end else begin
          poll_q <= (poll_q == 4'd9) ? 4'd0 : poll_q + 4'd1;
        end
      end else begin
        cnt_q <= ph_last ? '0 : cnt_q + 1'b1;
        if (ph_last) begin
          case (st_q)
            ST_P1: begin
              st_q <= ST_P2;
              cs_q <= 1'b1;
              wr_q <= 1'b1;
              oe_q <= 1'b0;
            end
            ST_P2: begin
              st_q  <= ST_P3;
              cs_q  <= 1'b0;
              a_d_q <= 1'b1;
              if (is_wr_q) begin
                wr_q   <= 1'b0;
                oe_q   <= 1'b1;
                dato_q <= wdata_q;
              end else begin
                rd_q <= 1'b0;
              end
            end
            ST_P3: begin
              st_q    <= ST_P4;
              rdata_q <= bus.dato_i;
              cs_q    <= 1'b1;
              rd_q    <= 1'b1;
              wr_q    <= 1'b1;
              oe_q    <= 1'b0;
              a_d_q   <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      // Mode changes queue the old group's write-back; later exits take precedence.
      if (mode_d != mode_q) begin
        if (mode_q != 2'd0) begin
          wr_pend_q <= 1'b1;
          wr_grp_q  <= mode_q;
          wr_idx_q  <= 2'd0;
          if (mode_q == 2'd3 && (val_q[7] | val_q[8] | val_q[9]) != 8'h00) armed_q <= 1'b1;
        end
        cursor_q <= 2'd0;
      end else if (mode_q != 2'd0) begin
        if (enRIGHT) cursor_q <= (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
        else if (enLEFT) cursor_q <= (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
        if (enUP) val_q[fi] <= bcd_inc(val_q[fi], lo_of(fi), hi_of(fi));
        else if (enDOWN) val_q[fi] <= bcd_dec(val_q[fi], lo_of(fi), hi_of(fi));
      end
      mode_q <= mode_d;

      if (desactivar_alarma) estado_q <= 1'b0;
      else if (alarm_set) estado_q <= 1'b1;
    end
  end

  logic [4:0] hbin, hsub;

  // Hour display: chip value is 24 h BCD, converted only at the output
  always_comb begin
    hbin          = {1'b0, val_q[2][7:4]} * 5'd10 + {1'b0, val_q[2][3:0]};
    hsub          = hbin - 5'd12;
    out_hora_hora = val_q[2];
    AM_PM         = 1'b0;
    if (formato_hora) begin
      if (val_q[2] == 8'h00) begin
        out_hora_hora = 8'h12;
      end else if (val_q[2] == 8'h12) begin
        AM_PM = 1'b1;
      end else if (val_q[2] > 8'h12) begin
        AM_PM         = 1'b1;
        out_hora_hora = (hsub >= 5'd10) ? {4'h1, 4'(hsub - 5'd10)} : {4'h0, hsub[3:0]};
      end
    end
  end

  assign bus.cs        = cs_q;
  assign bus.rd        = rd_q;
  assign bus.wr        = wr_q;
  assign bus.a_d       = a_d_q;
  assign bus.dato_oe   = oe_q;
  assign bus.dato_o    = dato_q;
  assign bus.dbg_state = st_q;

  assign out_seg_hora    = val_q[0];
  assign out_min_hora    = val_q[1];
  assign out_dia_fecha   = val_q[3];
  assign out_mes_fecha   = val_q[4];
  assign out_jahr_fecha  = val_q[5];
  assign out_dia_semana  = val_q[6];
  assign out_seg_timer   = val_q[7];
  assign out_min_timer   = val_q[8];
  assign out_hora_timer  = val_q[9];
  assign estado_alarma   = estado_q;
  assign cursor_location = cursor_q;
endmodule

// File: tb/tb_rtc_control.sv
// Bench for rtc_control: RTC chip model on the bus, directed stimulus,
// write-back scoreboard with expected queue, final summary.
module tb_rtc_control;
  localparam int B_UP = 0, B_DOWN = 1, B_RIGHT = 2, B_LEFT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw0 = 0, sw1 = 0, sw2 = 0;
  logic enUP = 0, enDOWN = 0, enRIGHT = 0, enLEFT = 0;
  logic desactivar_alarma = 0, formato_hora = 0;
  logic [7:0] out_seg_hora, out_min_hora, out_hora_hora, out_dia_fecha, out_mes_fecha;
  logic [7:0] out_jahr_fecha, out_dia_semana, out_seg_timer, out_min_timer, out_hora_timer;
  logic estado_alarma, AM_PM;
  logic [1:0] cursor_location;

  rtc_control_if bus();

  rtc_control #(.PH(10)) dut (
    .clk(clk), .reset(reset),
    .sw0(sw0), .sw1(sw1), .sw2(sw2),
    .enUP(enUP), .enDOWN(enDOWN), .enRIGHT(enRIGHT), .enLEFT(enLEFT),
    .desactivar_alarma(desactivar_alarma), .formato_hora(formato_hora),
    .bus(bus),
    .out_seg_hora(out_seg_hora), .out_min_hora(out_min_hora), .out_hora_hora(out_hora_hora),
    .out_dia_fecha(out_dia_fecha), .out_mes_fecha(out_mes_fecha), .out_jahr_fecha(out_jahr_fecha),
    .out_dia_semana(out_dia_semana), .out_seg_timer(out_seg_timer), .out_min_timer(out_min_timer),
    .out_hora_timer(out_hora_timer), .estado_alarma(estado_alarma),
    .cursor_location(cursor_location), .AM_PM(AM_PM)
  );

  // Clock
  always #10 clk = ~clk;

  // Checking counters
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // RTC chip model: latches the address in phase 1, applies writes in phase 3
  logic [7:0] chip_mem [256];
  logic [7:0] lat_addr = 8'h00;
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'h00, poke_val = 8'h00;

  assign bus.dato_i = bus.rd ? 8'h00 : chip_mem[lat_addr];

  always @(negedge clk) begin
    if (poke_en) chip_mem[poke_addr] = poke_val;
    if (!bus.cs && !bus.a_d && bus.dato_oe) lat_addr = bus.dato_o;
    if (!bus.cs && bus.a_d && !bus.wr && bus.dato_oe) chip_mem[lat_addr] = bus.dato_o;
  end

  // Scoreboard: expected write-backs {addr, data}
  logic [15:0] exp_q[$];
  logic        sb_en = 1'b1;
  logic        in_wdata = 1'b0;
  logic [15:0] exp_w;

  always @(negedge clk) begin
    if (!bus.cs && bus.a_d && !bus.wr && !in_wdata) begin
      in_wdata = 1'b1;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", lat_addr, bus.dato_o);
        end else begin
          exp_w = exp_q.pop_front();
          check("bus_write", {lat_addr, bus.dato_o}, exp_w);
        end
      end
    end else if (bus.wr) begin
      in_wdata = 1'b0;
    end
  end

  // Driver tasks
  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(posedge clk);
    poke_addr = a;
    poke_val  = v;
    poke_en   = 1'b1;
    @(posedge clk);
    poke_en   = 1'b0;
  endtask

  task automatic pulse(input int b);
    @(negedge clk);
    case (b)
      B_UP:    enUP = 1'b1;
      B_DOWN:  enDOWN = 1'b1;
      B_RIGHT: enRIGHT = 1'b1;
      default: enLEFT = 1'b1;
    endcase
    @(negedge clk);
    enUP = 0; enDOWN = 0; enRIGHT = 0; enLEFT = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic found;

  // Stimulus
  initial begin
    poke(8'h21, 8'h45); poke(8'h22, 8'h30); poke(8'h23, 8'h15);
    poke(8'h24, 8'h01); poke(8'h25, 8'h06); poke(8'h26, 8'h24);
    poke(8'h27, 8'h03); poke(8'h41, 8'h00); poke(8'h42, 8'h00);
    poke(8'h43, 8'h00);

    // Reset state
    @(negedge clk);
    check("rst_strobes", {bus.cs, bus.rd, bus.wr, bus.a_d, bus.dato_oe}, 16'b11100);
    check("rst_outputs", {out_seg_hora, out_hora_hora}, 16'h0000);
    check("rst_misc", {cursor_location, estado_alarma, AM_PM, out_seg_timer}, 16'h0000);

    // First read transaction
    reset = 1'b1;
    wait_cyc(1);
    check("p1_strobes", {bus.cs, bus.a_d, bus.wr, bus.rd, bus.dato_oe}, 16'b00011);
    check("p1_addr", bus.dato_o, 16'h21);
    wait_cyc(9);
    check("p1_end", {bus.cs, bus.a_d, bus.wr, bus.dato_oe, bus.dato_o}, {4'b0001, 8'h21});
    wait_cyc(1);
    check("p2_idle", {bus.cs, bus.rd, bus.wr, bus.dato_oe}, 16'b1110);
    wait_cyc(10);
    check("p3_read", {bus.cs, bus.a_d, bus.rd, bus.wr, bus.dato_oe}, 16'b01010);
    wait_cyc(19);
    check("sec_before_store", out_seg_hora, 16'h00);
    wait_cyc(1);
    check("sec_after_store", out_seg_hora, 16'h45);

    // Full poll and hour display
    wait_cyc(400);
    check("poll_min", out_min_hora, 16'h30);
    check("poll_date", {out_dia_fecha, out_mes_fecha}, 16'h0106);
    check("poll_year_wd", {out_jahr_fecha, out_dia_semana}, 16'h2403);
    check("hour_24h", {AM_PM, out_hora_hora}, {1'b0, 8'h15});
    formato_hora = 1'b1;
    #1;
    check("hour_12h_pm", {AM_PM, out_hora_hora}, {1'b1, 8'h03});
    poke(8'h23, 8'h00);
    wait_cyc(450);
    check("hour_12h_midnight", {AM_PM, out_hora_hora}, {1'b0, 8'h12});
    poke(8'h23, 8'h12);
    wait_cyc(450);
    check("hour_12h_noon", {AM_PM, out_hora_hora}, {1'b1, 8'h12});
    formato_hora = 1'b0;
    #1;
    check("hour_24h_noon", {AM_PM, out_hora_hora}, {1'b0, 8'h12});
    poke(8'h23, 8'h23);
    wait_cyc(450);

    // Time edit and write-back
    @(negedge clk) sw0 = 1'b1;
    pulse(B_RIGHT); pulse(B_RIGHT); pulse(B_UP);
    check("time_cursor", cursor_location, 16'd2);
    check("time_hour_wrap", out_hora_hora, 16'h00);
    check("time_sec_hold", out_seg_hora, 16'h45);
    exp_q.push_back({8'h21, 8'h45});
    exp_q.push_back({8'h22, 8'h30});
    exp_q.push_back({8'h23, 8'h00});
    @(negedge clk) sw0 = 1'b0;
    wait_cyc(250);
    check("time_wb_drained", exp_q.size(), 16'd0);
    wait_cyc(450);
    check("time_reread", out_hora_hora, 16'h00);

    // Date edit, then direct switch to timer
    @(negedge clk) sw1 = 1'b1;
    wait_cyc(2);
    check("date_cursor0", cursor_location, 16'd0);
    pulse(B_DOWN);
    check("day_wrap_down", out_dia_fecha, 16'h31);
    pulse(B_LEFT);
    check("cursor_left_wrap", cursor_location, 16'd2);
    pulse(B_UP);
    check("year_up", out_jahr_fecha, 16'h25);
    pulse(B_RIGHT);
    check("cursor_right_wrap", cursor_location, 16'd0);
    exp_q.push_back({8'h24, 8'h31});
    exp_q.push_back({8'h25, 8'h06});
    exp_q.push_back({8'h26, 8'h25});
    @(negedge clk) sw2 = 1'b1;
    @(negedge clk) sw1 = 1'b0;
    wait_cyc(2);
    check("timer_cursor0", cursor_location, 16'd0);
    for (int i = 0; i < 5; i++) pulse(B_UP);
    check("timer_sec_edit", out_seg_timer, 16'h05);
    wait_cyc(250);
    check("date_wb_drained", exp_q.size(), 16'd0);
    exp_q.push_back({8'h41, 8'h05});
    exp_q.push_back({8'h42, 8'h00});
    exp_q.push_back({8'h43, 8'h00});
    @(negedge clk) sw2 = 1'b0;
    wait_cyc(250);
    check("timer_wb_drained", exp_q.size(), 16'd0);

    // Alarm
    wait_cyc(450);
    check("alarm_not_yet", {estado_alarma, out_seg_timer}, {1'b0, 8'h05});
    poke(8'h41, 8'h00);
    wait_cyc(900);
    check("alarm_set", {estado_alarma, out_seg_timer}, {1'b1, 8'h00});
    @(negedge clk) desactivar_alarma = 1'b1;
    @(negedge clk) desactivar_alarma = 1'b0;
    check("alarm_cleared", estado_alarma, 16'd0);
    wait_cyc(900);
    check("alarm_disarmed", estado_alarma, 16'd0);

    // Reset during a write
    sb_en = 1'b0;
    @(negedge clk) sw0 = 1'b1;
    wait_cyc(2);
    sw0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (!bus.cs && bus.a_d && !bus.wr) found = 1'b1;
    end
    check("wr_phase_seen", found, 16'd1);
    #3 reset = 1'b0;
    #1;
    check("rst_mid_strobes", {bus.cs, bus.rd, bus.wr, bus.a_d, bus.dato_oe}, 16'b11100);
    check("rst_mid_outputs", {out_seg_hora, out_dia_fecha}, 16'h0000);
    check("rst_mid_state", {bus.dbg_state, estado_alarma, out_hora_hora}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rtc_control.md
# rtc_control

Controller between the user-interface logic and an external real-time-clock chip on an 8-bit multiplexed address/data bus. It continuously polls the clock, date and countdown-timer registers and presents them as BCD outputs for display. It lets the user edit time, date or timer through switch modes and push-button pulses, writes the edits back to the chip, and raises an alarm flag when an armed timer expires.

## Interface
- PH, 10: clk cycles per bus phase.
- clk  in  1  system clock (50 MHz), all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- sw0 / sw1 / sw2  in  1 each  edit mode: time, date, timer. Priority sw0 > sw1 > sw2.
- enUP / enDOWN / enRIGHT / enLEFT  in  1 each  one-cycle button pulses.
- desactivar_alarma  in  1  clears estado_alarma.
- formato_hora  in  1  0 = 24 h display, 1 = 12 h display.
- dato  inout  8  multiplexed address/data bus. Hi-Z unless writing.
- a_d  out  1  0 = address phase, 1 = data phase.
- cs / rd / wr  out  1 each  active-low strobes.
- out_seg_hora, out_min_hora, out_hora_hora, out_dia_fecha, out_mes_fecha, out_jahr_fecha, out_dia_semana, out_seg_timer, out_min_timer, out_hora_timer  out  8 each  BCD values.
- estado_alarma  out  1  timer-expired flag.
- cursor_location  out  2  field being edited: 0 = seconds/day, 1 = minutes/month, 2 = hours/year.
- AM_PM  out  1  1 = PM in 12 h mode. Always 0 in 24 h mode.

## Operation
- Register addresses: sec 0x21, min 0x22, hour 0x23, day 0x24, month 0x25, year 0x26, weekday 0x27, timer sec 0x41, timer min 0x42, timer hour 0x43. The chip stores hours as 24 h BCD.
- **Bus write**, four phases of PH cycles each:
  - phase 1: cs=0, a_d=0, wr=0, dato=address.
  - phase 2: all strobes high, dato Hi-Z.
  - phase 3: cs=0, a_d=1, wr=0, dato=data.
  - phase 4: idle.
- **Bus read**: same four phases, except phase 3 is cs=0, a_d=1, rd=0 with dato Hi-Z. Data is sampled on the last cycle of phase 3.
- **Normal mode** (all switches low):
  - Round-robin reads of the 10 addresses in the order listed above.
  - Each read value is stored into its output register at the end of the transaction.
- **Edit mode** (any switch high):
  - Polling continues, but reads of the edited group do not update its registers.
  - The three registers of the group are loaded as edit values when the mode is entered.
  - Groups: time = sec/min/hour; date = day/month/year; timer = timer sec/min/hour.
  - enRIGHT increments the cursor 0→1→2→0; enLEFT decrements it 0→2.
  - enUP / enDOWN change the selected field by ±1 in BCD with wrap-around:
    - sec/min 00–59, hours 00–23;
    - day 01–31, month 01–12, year 00–99.
    - Example: 59 + 1 → 00; 01 − 1 → 31 for day.
  - The edited group's outputs show the edit values live.
- **Exit from edit mode** (switch falls):
  - Finish the current transaction, then write the three edited registers in order sec/min/hour (or day/month/year), then resume polling.
  - Exiting timer mode with a nonzero value sets an internal armed flag.
- **Mode changes while editing**: switching directly to another mode first performs the exit write for the old group. The cursor resets to 0 on every mode entry.
- **Alarm**:
  - When armed and a polled timer read gives 00:00:00, estado_alarma is set to 1 and armed is cleared.
  - desactivar_alarma (level) clears estado_alarma. It has priority over setting in the same cycle.
- **Hour display**:
  - formato_hora=1 converts hour 00 → 12 AM, 01–11 → AM, 12 → 12 PM, 13–23 → h−12 PM.
  - Edit values stay 24 h internally; only the output is converted.

## Timing
- Reset (asynchronous, reset=0):
  - all BCD outputs 0x00, cursor_location 0, estado_alarma 0, AM_PM 0;
  - cs=rd=wr=1, a_d=0, dato Hi-Z, armed 0.
  - Any transaction in progress is aborted.
- After release, the first read (address 0x21) starts on the first clk edge.
- One transaction = 4·PH cycles (40 cycles, 800 ns at default).
- A full poll cycle = 10 transactions = 400 cycles.
- Button pulses take effect on the next cycle. Buttons arriving during a bus transaction are still applied; they are not queued.
- AM_PM and out_hora_hora update in the same cycle as the hour register or formato_hora changes (combinational from the register).
- dato is driven only during phases 1 and 3 of a write, and only during phase 1 of a read.

## Test plan
- Reset then release; bus model returns 0x45 for address 0x21 → first transaction shows a_d=0, cs=0, wr=0, dato=0x21 for 10 cycles; out_seg_hora becomes 0x45 after cycle 40.
- Bus model returns hour 0x15, formato_hora=1 → out_hora_hora=0x03, AM_PM=1; hour 0x00 → 0x12, AM_PM=0.
- sw0=1, then enRIGHT×2 and enUP from hour 0x23 → cursor_location=2, out_hora_hora=0x00; set sw0=0 → writes to 0x21, 0x22, 0x23 with the edited values.
- sw1=1, cursor 0, day=0x01, enDOWN → 0x31; enLEFT from cursor 0 → 2.
- sw2: set timer sec to 0x05, exit; model then returns 00:00:00 → estado_alarma=1; desactivar_alarma=1 → 0.
- Assert reset mid-write → strobes high and dato Hi-Z immediately; outputs zeroed.
